ws2812_pixel_buffer: RTL and testbench

Double-buffered per-LED colour store that sits directly upstream of the ws2812 serial driver and gives each LED in the chain its own colour. A host writes pixels into a back bank and commits the whole frame at once. On request, the front bank is streamed out pixel by pixel over a valid/ready interface, in LED order, to the driver's red/green/blue inputs. The bank swap is atomic at a frame boundary, so the chain never shows a partly written frame.

---
 rtl/ws2812_pixel_buffer.sv | 138 +++++++++++++
 tb/tb_ws2812_pixel_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_buffer.sv
// Double-buffered per-LED colour store feeding the ws2812 serial driver.
// The host fills the back bank and commits it; the front bank is streamed
// out one pixel at a time over valid/ready. Bank swaps only happen at a
// frame boundary, so a partly written frame is never displayed.
module ws2812_pixel_buffer #(
  parameter int unsigned LEDS = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_red,
  input  logic [7:0]    wr_green,
  input  logic [7:0]    wr_blue,
  input  logic          commit,
  output logic          commit_pending,
  input  logic          frame_start,
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [7:0]    pix_red,
  output logic [7:0]    pix_green,
  output logic [7:0]    pix_blue,
  output logic          pix_last
);

  localparam int unsigned IW = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam int unsigned PW = 24;
  localparam logic [AW-1:0] LAST_IDX = AW'(LEDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Two banks of LEDS pixels; contents survive reset.
  logic [PW-1:0] mem [0:1][0:LEDS-1];

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          front_q, front_d;
  logic          pending_d;
  logic          valid_d;
  logic          last_d;
  logic          busy_d;
  logic          swap_point;
  logic          swap_due;
  logic [PW-1:0] rd_word;

  // Front-bank read port; registered into the pixel outputs during LOAD.
  assign rd_word = mem[front_q][IW'(idx_q)];

  // Host writes always target the back bank; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < LEDS)) begin
      mem[~front_q][IW'(wr_addr)] <= {wr_red, wr_green, wr_blue};
    end
  end

  // Next-state, swap and registered-output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = pix_valid;
    last_d     = pix_last;
    swap_point = 1'b0;

    case (state_q)
      IDLE: begin
        swap_point = 1'b1;
        if (frame_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        state_d = STREAM;
        valid_d = 1'b1;
        last_d  = (idx_q == LAST_IDX);
      end
      STREAM: begin
        if (pix_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d    = IDLE;
            idx_d      = '0;
            swap_point = 1'b1;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    swap_due  = (commit | commit_pending) & swap_point;
    front_d   = swap_due ? ~front_q : front_q;
    pending_d = swap_due ? 1'b0 : (commit_pending | commit);
    busy_d    = (state_d != IDLE);
  end

  // State, bank selector and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      front_q        <= 1'b0;
      commit_pending <= 1'b0;
      busy           <= 1'b0;
      pix_valid      <= 1'b0;
      pix_last       <= 1'b0;
      pix_red        <= '0;
      pix_green      <= '0;
      pix_blue       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      front_q        <= front_d;
      commit_pending <= pending_d;
      busy           <= busy_d;
      pix_valid      <= valid_d;
      pix_last       <= last_d;
      if (state_q == LOAD) begin
        {pix_red, pix_green, pix_blue} <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_buffer.sv
// Self-checking bench for ws2812_pixel_buffer with a frame-level bank model.
module tb_ws2812_pixel_buffer;

  localparam int NL = 4;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_red, wr_green, wr_blue;
  logic          commit;
  logic          commit_pending;
  logic          frame_start;
  logic          busy;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_red, pix_green, pix_blue;
  logic          pix_last;

  ws2812_pixel_buffer #(.LEDS(NL), .AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_red         (wr_red),
    .wr_green       (wr_green),
    .wr_blue        (wr_blue),
    .commit         (commit),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .busy           (busy),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_red        (pix_red),
    .pix_green      (pix_green),
    .pix_blue       (pix_blue),
    .pix_last       (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame model: two pixel arrays, which one is shown, and a pending commit.
  logic [23:0] mbank [2][NL];
  int          mfront = 0;
  bit          mpend  = 0;

  // Results of the last captured frame.
  logic [23:0] exp_px[$];
  logic [23:0] cap_px[$];
  bit          cap_last[$];
  int          cap_bubble_err, cap_stable_err, cap_stalls, cap_first_valid;
  bit          cap_pend_seen, cap_pend_at_last, cap_timeout;
  logic        cap_busy_after, cap_pend_after, cap_valid_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_swap();
    mfront = 1 - mfront;
    mpend  = 0;
  endfunction

  task automatic do_write(input int addr, input logic [23:0] rgb);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    {wr_red, wr_green, wr_blue} = rgb;
    if (addr < NL) mbank[1-mfront][addr] = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_back_random();
    for (int i = 0; i < NL; i++) do_write(i, 24'($urandom()));
  endtask

  task automatic commit_idle();
    commit = 1'b1;
    m_swap();
    tick();
    commit = 1'b0;
  endtask

  // Streams one frame, optionally stalling one pixel and injecting events.
  task automatic capture(input int stall_px, input int stall_n, input bit with_commit,
                         input bit inject_writes, input bit inject_fs);
    int k = 0;
    int stall = 0;
    int cycles = 0;
    bit prev_acc = 0;
    bit acc;
    logic [23:0] held = '0;
    cap_px.delete(); cap_last.delete(); exp_px.delete();
    cap_bubble_err = 0; cap_stable_err = 0; cap_stalls = 0; cap_first_valid = -1;
    cap_pend_seen = 0; cap_pend_at_last = 0; cap_timeout = 0;
    frame_start = 1'b1;
    if (with_commit) begin
      commit = 1'b1;
      m_swap();
    end
    for (int i = 0; i < NL; i++) exp_px.push_back(mbank[mfront][i]);
    tick();
    frame_start = 1'b0;
    commit = 1'b0;
    while (k < NL) begin
      if (cycles >= 200) begin
        cap_timeout = 1;
        break;
      end
      if (commit_pending) cap_pend_seen = 1;
      if (prev_acc && pix_valid) cap_bubble_err++;
      if (cap_first_valid < 0 && pix_valid) cap_first_valid = cycles;
      pix_ready = 1'b1;
      if (pix_valid && k == stall_px && stall < stall_n) begin
        pix_ready = 1'b0;
        if (stall == 0) held = {pix_red, pix_green, pix_blue};
        else if ({pix_red, pix_green, pix_blue} !== held) cap_stable_err++;
        if (inject_writes) begin
          if (stall < NL) begin
            wr_en = 1'b1;
            wr_addr = AW'(stall);
            {wr_red, wr_green, wr_blue} = 24'hFFFFFF;
            mbank[1-mfront][stall] = 24'hFFFFFF;
          end else if (stall == NL) begin
            commit = 1'b1;
            mpend = 1;
          end
        end
        stall++;
        cap_stalls++;
      end
      if (inject_fs && k == 2 && pix_valid) frame_start = 1'b1;
      acc = pix_valid && pix_ready;
      if (acc) begin
        cap_px.push_back({pix_red, pix_green, pix_blue});
        cap_last.push_back(pix_last);
        k++;
        if (k == NL) begin
          cap_pend_at_last = commit_pending;
          if (mpend) m_swap();
        end
      end
      tick();
      cycles++;
      wr_en = 1'b0;
      commit = 1'b0;
      frame_start = 1'b0;
      prev_acc = acc;
    end
    cap_busy_after  = busy;
    cap_pend_after  = commit_pending;
    cap_valid_after = pix_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    mfront = 0; mpend = 0;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", pix_valid); else n_pass++;
    n_checks++; if (pix_last !== 1'b0) $display("FAIL reset_last got=%b want=0", pix_last); else n_pass++;
    n_checks++; if ({pix_red, pix_green, pix_blue} !== 24'h0) $display("FAIL reset_data got=%h want=000000", {pix_red, pix_green, pix_blue}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (commit_pending !== 1'b0) $display("FAIL reset_pending got=%b want=0", commit_pending); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < NL; i++) do_write(i, {8'(i * 16), 8'(i + 1), 8'hA0});
    commit_idle();
    n_checks++; if (commit_pending !== 1'b0) $display("FAIL idle_commit_pending got=%b want=0", commit_pending); else n_pass++;
    capture(-1, 0, 0, 0, 0);
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL basic_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== {8'(i * 16), 8'(i + 1), 8'hA0}) $display("FAIL basic_px%0d got=%h want=%h", i, cap_px[i], {8'(i * 16), 8'(i + 1), 8'hA0}); else n_pass++;
      n_checks++; if (cap_last[i] !== (i == NL - 1)) $display("FAIL basic_last%0d got=%b want=%b", i, cap_last[i], (i == NL - 1)); else n_pass++;
    end
    n_checks++; if (cap_first_valid != 1) $display("FAIL basic_latency got=%0d want=1", cap_first_valid); else n_pass++;
    n_checks++; if (cap_bubble_err != 0) $display("FAIL basic_bubble got=%0d want=0", cap_bubble_err); else n_pass++;
    n_checks++; if (cap_busy_after !== 1'b0) $display("FAIL basic_busy_after got=%b want=0", cap_busy_after); else n_pass++;
    n_checks++; if (cap_valid_after !== 1'b0 || pix_last !== 1'b0) $display("FAIL basic_valid_after got=%b/%b want=0/0", cap_valid_after, pix_last); else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 4; r++) begin
      fill_back_random();
      commit_idle();
      capture(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 4)), 0, 0, 0);
      n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL rand%0d_count got=%0d want=%0d", r, cap_px.size(), NL); else n_pass++;
      for (int i = 0; i < NL && i < cap_px.size(); i++) begin
        n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL rand%0d_px%0d got=%h want=%h", r, i, cap_px[i], exp_px[i]); else n_pass++;
      end
      n_checks++; if (cap_stable_err != 0 || cap_bubble_err != 0) $display("FAIL rand%0d_protocol got=%0d/%0d want=0/0", r, cap_stable_err, cap_bubble_err); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    capture(1, 5, 0, 0, 0);
    n_checks++; if (cap_stalls != 5) $display("FAIL bp_stalls got=%0d want=5", cap_stalls); else n_pass++;
    n_checks++; if (cap_stable_err != 0) $display("FAIL bp_stable got=%0d want=0", cap_stable_err); else n_pass++;
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL bp_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL bp_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
  endtask

  task automatic test_deferred_swap();
    capture(1, 5, 0, 1, 0);
    n_checks++; if (cap_pend_seen !== 1'b1) $display("FAIL defer_pending_seen got=%b want=1", cap_pend_seen); else n_pass++;
    n_checks++; if (cap_pend_at_last !== 1'b1) $display("FAIL defer_pending_at_last got=%b want=1", cap_pend_at_last); else n_pass++;
    n_checks++; if (cap_pend_after !== 1'b0) $display("FAIL defer_pending_after got=%b want=0", cap_pend_after); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL defer_old_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
    capture(-1, 0, 0, 0, 0);
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL defer_new_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== 24'hFFFFFF) $display("FAIL defer_new_px%0d got=%h want=ffffff", i, cap_px[i]); else n_pass++;
    end
  endtask

  task automatic test_write_isolation();
    fill_back_random();
    do_write(5, 24'h123456);
    capture(-1, 0, 0, 0, 0);
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL iso_front_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
    commit_idle();
    capture(-1, 0, 0, 0, 0);
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL iso_back_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    fill_back_random();
    capture(-1, 0, 1, 0, 0);
    n_checks++; if (cap_pend_seen !== 1'b0) $display("FAIL simul_pending got=%b want=0", cap_pend_seen); else n_pass++;
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL simul_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL simul_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    bit extra = 0;
    capture(-1, 0, 0, 0, 1);
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL fsbusy_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (pix_valid || busy) extra = 1;
      tick();
    end
    n_checks++; if (extra !== 1'b0) $display("FAIL fsbusy_extra_frame got=%b want=0", extra); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int accepted = 0;
    int cycles = 0;
    bit reached = 0;
    fill_back_random();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    commit = 1'b1;
    mpend = 1;
    pix_ready = 1'b1;
    while (cycles < 50) begin
      if (pix_valid && accepted == 2) begin
        reached = 1;
        break;
      end
      if (pix_valid) accepted++;
      tick();
      commit = 1'b0;
      cycles++;
    end
    n_checks++; if (reached !== 1'b1) $display("FAIL rstmid_reach got=%b want=1", reached); else n_pass++;
    n_checks++; if (commit_pending !== 1'b1) $display("FAIL rstmid_pending_before got=%b want=1", commit_pending); else n_pass++;
    pix_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mfront = 0;
    mpend = 0;
    pix_ready = 1'b1;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", pix_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (commit_pending !== 1'b0) $display("FAIL rstmid_pending got=%b want=0", commit_pending); else n_pass++;
    tick();
    capture(-1, 0, 0, 0, 0);
    n_checks++; if (cap_timeout || cap_px.size() != NL) $display("FAIL rstmid_count got=%0d want=%0d", cap_px.size(), NL); else n_pass++;
    for (int i = 0; i < NL && i < cap_px.size(); i++) begin
      n_checks++; if (cap_px[i] !== exp_px[i]) $display("FAIL rstmid_px%0d got=%h want=%h", i, cap_px[i], exp_px[i]); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_red = '0;
    wr_green = '0;
    wr_blue = '0;
    commit = 1'b0;
    frame_start = 1'b0;
    pix_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_backpressure();
    test_deferred_swap();
    test_write_isolation();
    test_simultaneous();
    test_start_while_busy();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
